// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: datapath defaults,
// the zero-instruction constant and the fetch FSM state type.
package ifu_fetch_pkg;

  localparam int unsigned XLEN_DEFAULT     = 64;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
  localparam logic [31:0] INST_ZERO        = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, keeps a single read outstanding to
// instruction memory and hands {inst, inst_pc, inst_fault} to decode over a
// valid/ready handshake. Redirects from execute take priority over everything.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] inst_pc_nxt;
  logic [31:0]     inst_nxt;
  logic            drop, drop_nxt;
  logic            inst_valid_nxt, inst_fault_nxt, req_valid_nxt;
  logic            req_fire, consumed, misaligned;
  logic            in_flight, in_flight_after;

  assign imem_req_addr = pc;
  assign req_fire      = imem_req_valid & imem_req_ready;
  assign consumed      = inst_valid & inst_ready;
  assign misaligned    = (redirect_pc[1:0] != 2'b00);

  // A read is outstanding while waiting, or while a discarded response is
  // still owed (drop can survive into S_HOLD after a misaligned redirect).
  assign in_flight       = (state == S_WAIT) | drop;
  assign in_flight_after = (in_flight & ~imem_rsp_valid) | req_fire;

  // Next-state and next-output selection; redirect overrides normal flow.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    drop_nxt       = drop;
    inst_valid_nxt = inst_valid;
    inst_nxt       = inst;
    inst_pc_nxt    = inst_pc;
    inst_fault_nxt = inst_fault;

    if (state == S_BOOT) begin
      state_nxt = S_REQ;
      if (redirect_valid) begin
        pc_nxt = redirect_pc;
        if (misaligned) begin
          inst_valid_nxt = 1'b1;
          inst_nxt       = INST_ZERO;
          inst_fault_nxt = 1'b1;
          inst_pc_nxt    = redirect_pc;
          state_nxt      = S_HOLD;
        end
      end
    end else if (redirect_valid) begin
      // Any read still owed after this cycle must be swallowed before the
      // next request goes out, so drop tracks it across S_WAIT and S_HOLD.
      pc_nxt         = redirect_pc;
      drop_nxt       = in_flight_after;
      inst_valid_nxt = 1'b0;
      if (misaligned) begin
        inst_valid_nxt = 1'b1;
        inst_nxt       = INST_ZERO;
        inst_fault_nxt = 1'b1;
        inst_pc_nxt    = redirect_pc;
        state_nxt      = S_HOLD;
      end else begin
        state_nxt = in_flight_after ? S_WAIT : S_REQ;
      end
    end else begin
      unique case (state)
        S_REQ: begin
          if (req_fire) state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (drop) begin
              drop_nxt  = 1'b0;
              state_nxt = S_REQ;
            end else begin
              inst_valid_nxt = 1'b1;
              inst_nxt       = imem_rsp_err ? INST_ZERO : imem_rsp_data;
              inst_pc_nxt    = pc;
              inst_fault_nxt = imem_rsp_err;
              pc_nxt         = pc + XLEN'(4);
              state_nxt      = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (drop && imem_rsp_valid) drop_nxt = 1'b0;
          if (consumed) begin
            inst_valid_nxt = 1'b0;
            state_nxt      = (drop && !imem_rsp_valid) ? S_WAIT : S_REQ;
          end
        end
        default: ;
      endcase
    end

    req_valid_nxt = (state_nxt == S_REQ);
  end

  // State, PC and registered decode/imem outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_BOOT;
      pc             <= RESET_PC;
      drop           <= 1'b0;
      imem_req_valid <= 1'b0;
      inst_valid     <= 1'b0;
      inst           <= INST_ZERO;
      inst_pc        <= '0;
      inst_fault     <= 1'b0;
    end else begin
      state          <= state_nxt;
      pc             <= pc_nxt;
      drop           <= drop_nxt;
      imem_req_valid <= req_valid_nxt;
      inst_valid     <= inst_valid_nxt;
      inst           <= inst_nxt;
      inst_pc        <= inst_pc_nxt;
      inst_fault     <= inst_fault_nxt;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios followed by a randomized phase,
// with a memory responder process and an instruction-stream model.
module tb_ifu_fetch;

  localparam int unsigned XLEN    = 64;
  localparam logic [63:0] BOOT_PC = 64'h0000_0000_8000_0000;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            imem_rsp_err;
  logic            inst_valid;
  logic            inst_ready = 1'b0;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_fault;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;

  int n_pass  = 0;
  int n_total = 0;

  // memory responder configuration and bookkeeping
  int          rdy_mode = 1;      // 0 never, 1 always, 2 random
  int          lat      = 1;
  bit          lat_rand = 1'b0;
  bit          rand_err = 1'b0;
  logic [63:0] err_addr = '1;
  bit          pend     = 1'b0;
  int          cnt      = 0;
  logic [63:0] paddr    = '0;
  int          n_acc    = 0;
  logic [63:0] last_acc = '0;

  always #5 clk = ~clk;

  ifu_fetch #(.XLEN(XLEN), .RESET_PC(BOOT_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  function automatic logic [31:0] memw(input logic [63:0] a);
    logic [31:0] off;
    off = a[31:0] - 32'h8000_0000;
    return off * 32'd2654435761 + 32'h0000_0013;
  endfunction

  function automatic logic memerr(input logic [63:0] a);
    return (a == err_addr) || (rand_err && (a[6:2] == 5'h13));
  endfunction

  function automatic logic [31:0] exp_inst(input logic [63:0] a);
    return memerr(a) ? 32'h0 : memw(a);
  endfunction

  // Memory: acts 2 time units after each rising edge, one read in flight.
  initial begin
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      imem_rsp_valid = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = memw(paddr);
          imem_rsp_err   = memerr(paddr);
          pend           = 1'b0;
        end
      end
      case (rdy_mode)
        0:       imem_req_ready = 1'b0;
        1:       imem_req_ready = 1'b1;
        default: imem_req_ready = 1'($urandom_range(0, 1));
      endcase
      if (imem_req_valid && imem_req_ready) begin
        pend     = 1'b1;
        cnt      = lat_rand ? int'($urandom_range(1, 4)) : lat;
        paddr    = imem_req_addr;
        n_acc++;
        last_acc = imem_req_addr;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_inst(input string tag, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!inst_valid && cyc < 40);
    chk({tag, "_valid"}, 64'(inst_valid), 64'd1);
  endtask

  task automatic expect_inst(input string tag, input logic [63:0] pc, input logic fault);
    int c;
    wait_inst(tag, c);
    chk({tag, "_pc"}, inst_pc, pc);
    chk({tag, "_inst"}, 64'(inst), fault ? 64'd0 : 64'(memw(pc)));
    chk({tag, "_fault"}, 64'(inst_fault), 64'(fault));
  endtask

  task automatic consume();
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
  endtask

  initial begin
    int          cyc;
    int          acc0;
    int          n_cons;
    logic [63:0] exp_pc;
    logic [63:0] tgt;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_inst_pc", inst_pc, 64'd0);
    chk("rst_fault", 64'(inst_fault), 64'd0);
    chk("rst_addr", imem_req_addr, BOOT_PC);

    // 1: first fetch after reset release
    rst = 1'b1;
    wait_inst("t1", cyc);
    chk("t1_latency", 64'(cyc), 64'd3);
    chk("t1_pc", inst_pc, BOOT_PC);
    chk("t1_inst", 64'(inst), 64'h13);
    chk("t1_acc_addr", last_acc, BOOT_PC);
    chk("t1_acc_count", 64'(n_acc), 64'd1);

    // 2: decode stalls, outputs hold and no request is issued
    acc0 = n_acc;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_hold_pc", inst_pc, BOOT_PC);
      chk("t2_hold_out", {29'd0, imem_req_valid, inst_valid, inst_fault, inst},
          {29'd0, 1'b0, 1'b1, 1'b0, 32'h13});
    end
    chk("t2_no_req", 64'(n_acc), 64'(acc0));
    consume();
    chk("t2_consumed", 64'(inst_valid), 64'd0);
    expect_inst("t2_next", BOOT_PC + 64'd4, 1'b0);
    chk("t2_next_acc", last_acc, BOOT_PC + 64'd4);

    // 3: redirect in S_WAIT with the response arriving the same cycle
    consume();
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1000;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t3_dropped", 64'(inst_valid), 64'd0);
    chk("t3_req_addr", imem_req_addr, 64'h8000_1000);
    expect_inst("t3_target", 64'h8000_1000, 1'b0);
    chk("t3_acc_addr", last_acc, 64'h8000_1000);

    // 4: misaligned redirect while the request is not accepted
    rdy_mode = 0;
    consume();
    acc0 = n_acc;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0002;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t4_valid", 64'(inst_valid), 64'd1);
    chk("t4_fault", 64'(inst_fault), 64'd1);
    chk("t4_inst", 64'(inst), 64'd0);
    chk("t4_pc", inst_pc, 64'h8000_0002);
    chk("t4_req_valid", 64'(imem_req_valid), 64'd0);
    repeat (2) @(negedge clk);
    chk("t4_no_req", 64'(n_acc), 64'(acc0));

    // 5: access fault on fetch at 'h80000008, next fetch clean
    err_addr = 64'h8000_0008;
    rdy_mode = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0008;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t5_cleared", 64'(inst_valid), 64'd0);
    expect_inst("t5_err", 64'h8000_0008, 1'b1);
    consume();
    expect_inst("t5_after", 64'h8000_000C, 1'b0);

    // 6a: PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    expect_inst("t6_top", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    consume();
    expect_inst("t6_wrap", 64'd0, 1'b0);
    chk("t6_wrap_acc", last_acc, 64'd0);

    // 6b: reset pulse in S_WAIT, the late response must be ignored
    lat = 4;
    consume();
    rdy_mode = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_valid", 64'(inst_valid), 64'd0);
    chk("t6_rst_req", 64'(imem_req_valid), 64'd0);
    chk("t6_rst_addr", imem_req_addr, BOOT_PC);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_late_ignored", 64'(inst_valid), 64'd0);
    end
    chk("t6_restart_req", 64'(imem_req_valid), 64'd1);
    chk("t6_restart_addr", imem_req_addr, BOOT_PC);
    lat      = 1;
    rdy_mode = 1;
    expect_inst("t6_restart", BOOT_PC, 1'b0);
    chk("t6_restart_acc", last_acc, BOOT_PC);

    // randomized phase: stream of fetched words checked against address model
    err_addr = '1;
    rand_err = 1'b1;
    lat_rand = 1'b1;
    rdy_mode = 2;
    consume();
    exp_pc = BOOT_PC + 64'd4;
    n_cons = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      redirect_valid = 1'b0;
      inst_ready     = ($urandom_range(0, 3) != 0);
      if (inst_valid && inst_ready) begin
        chk("rnd_pc", inst_pc, exp_pc);
        chk("rnd_inst", 64'(inst), 64'(exp_inst(exp_pc)));
        chk("rnd_fault", 64'(inst_fault), 64'(memerr(exp_pc)));
        exp_pc = exp_pc + 64'd4;
        n_cons++;
      end
      if ($urandom_range(0, 19) == 0) begin
        tgt            = BOOT_PC + 64'($urandom_range(0, 1023)) * 64'd4;
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        exp_pc         = tgt;
      end
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    chk("rnd_progress", 64'(n_cons >= 20), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
